// File: rtl/mac_accum.sv
// mac_accum: signed fixed-point multiply-accumulate over groups of ACC_LEN
// operand pairs, with a valid/ready handshake on both sides.
// Optional feature macro: MAC_ACCUM_SAT_EN (saturating accumulation + ACC_SAT).
// Pipeline: the product is registered at acceptance, added to the accumulator
// on the next edge, and the result is held in HOLD until OUT_READY.
module mac_accum #(
    parameter int DWIDTH   = 16,
    parameter int DFRAC    = 13,
    parameter int ACCWIDTH = 33,
    parameter int ACC_LEN  = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic [DWIDTH-1:0]   IFMAP,
    input  logic [DWIDTH-1:0]   WEIGHT,
    input  logic                IN_VALID,
    output logic                IN_READY,
    output logic [ACCWIDTH-1:0] ACC_OUT,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                ACC_SAT
);

    localparam int STAGES = 1;
    localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

    // Reject configurations the datapath cannot represent.
    if (ACC_LEN < 1 || ACC_LEN > 255 || ACCWIDTH < 2*DWIDTH || DFRAC >= DWIDTH) begin : g_bad_cfg
        $error("mac_accum: unsupported parameter combination");
    end

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                      state, state_nxt;
    logic [7:0]                  count;
    logic [STAGES:0]             vld_pipe;   // [0] product valid, [1] product accumulated
    logic [STAGES:0]             last_pipe;  // last element of group rides with vld_pipe
    logic                        first_s1;   // product in stage 1 opens a new group
    logic signed [2*DWIDTH-1:0]  prod_full;
    logic [ACCWIDTH-1:0]         prod;
    logic [ACCWIDTH-1:0]         acc;
    logic [ACCWIDTH-1:0]         acc_nxt;
    logic                        accept;
    logic                        last_elem;

    assign IN_READY  = (state == ACCUM);
    assign OUT_VALID = (state == HOLD);
    assign ACC_OUT   = acc;
    // FLUSH discards whatever operand is presented in its cycle.
    assign accept    = IN_VALID & IN_READY & ~FLUSH;
    assign last_elem = (count == LAST_CNT);
    assign prod_full = $signed(IFMAP) * $signed(WEIGHT);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ACCUM;
        else       state <= state_nxt;
    end

    // Next-state logic; FLUSH overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_elem)         state_nxt = DRAIN;
            DRAIN:   if (vld_pipe[1] && last_pipe[1]) state_nxt = HOLD;
            HOLD:    if (OUT_READY)                   state_nxt = ACCUM;
            default:                                  state_nxt = ACCUM;
        endcase
        if (FLUSH) state_nxt = ACCUM;
    end

    // Element counter within the current group.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       count <= '0;
        else if (FLUSH)  count <= '0;
        else if (accept) count <= last_elem ? '0 : count + 8'd1;
    end

    // Stage 1: register the sign-extended product and its group markers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prod         <= '0;
            vld_pipe[0]  <= 1'b0;
            last_pipe[0] <= 1'b0;
            first_s1     <= 1'b0;
        end else begin
            vld_pipe[0]  <= accept;
            last_pipe[0] <= accept & last_elem;
            first_s1     <= accept & (count == 8'd0);
            if (accept) prod <= ACCWIDTH'(prod_full);
            if (FLUSH) vld_pipe[0] <= 1'b0;
        end
    end

`ifdef MAC_ACCUM_SAT_EN
    logic [ACCWIDTH:0] sum_ext;
    logic              ovf;
    logic              sat_q;

    // Widened add; the two top bits disagree exactly on overflow.
    always_comb begin
        sum_ext = {acc[ACCWIDTH-1], acc} + {prod[ACCWIDTH-1], prod};
        ovf     = sum_ext[ACCWIDTH] ^ sum_ext[ACCWIDTH-1];
        acc_nxt = sum_ext[ACCWIDTH-1:0];
        if (ovf && !sum_ext[ACCWIDTH]) acc_nxt = {1'b0, {(ACCWIDTH-1){1'b1}}};
        if (ovf &&  sum_ext[ACCWIDTH]) acc_nxt = {1'b1, {(ACCWIDTH-1){1'b0}}};
    end

    // Sticky group saturation flag, restarted by the first product of a group.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)            sat_q <= 1'b0;
        else if (FLUSH)       sat_q <= 1'b0;
        else if (vld_pipe[0]) sat_q <= first_s1 ? 1'b0 : (sat_q | ovf);
    end

    assign ACC_SAT = sat_q;
`else
    // Plain two's-complement wrap.
    always_comb begin
        acc_nxt = acc + prod;
    end

    assign ACC_SAT = 1'b0;
`endif

    // Stage 2: accumulate; the first product of a group replaces the sum.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc          <= '0;
            vld_pipe[1]  <= 1'b0;
            last_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1]  <= vld_pipe[0] & ~FLUSH;
            last_pipe[1] <= last_pipe[0];
            if (vld_pipe[0] && !FLUSH) acc <= first_s1 ? prod : acc_nxt;
        end
    end

endmodule
